// File: rtl/ir_fetch_unit.sv
// ---------------------------------------------------------------------------
// ir_fetch_unit
//
// Instruction fetch / instruction-register stage of the 16-bit accumulator
// processor. Holds the PC, runs a request/ready read of program memory,
// latches the returned word into IR, exposes the IR fields consumed by the
// sign extender, and adds the sign extender output to PC on a taken
// branch or jump.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   -> a REQ cycle counter aborts a fetch after TIMEOUT_CYCLES
//                REQ cycles without mem_ready (ERR state, fetch_err pulse).
//   undefined -> REQ waits indefinitely, fetch_err is tied to 0.
//
// Parameters:
//   RESET_PC       PC value after reset.
//   TIMEOUT_CYCLES maximum REQ cycles before abort (FETCH_TIMEOUT_EN only).
//
// Ports:
//   CLK           in   1  system clock, rising edge
//   Reset         in   1  synchronous, active-high reset
//   start_fetch   in   1  fetch instruction at PC (sampled in IDLE only)
//   pc_load       in   1  PC <= PC + SEOUT (sampled in IDLE only, wins)
//   SEOUT         in  16  sign-extended offset from the sign extender
//   mem_rdata     in  16  program memory read data
//   mem_ready     in   1  program memory data valid this cycle
//   mem_req       out  1  read request, high while in REQ
//   mem_addr      out 16  read address, always PC
//   IR            out 16  instruction register
//   IR_immediate  out 11  IR[10:0]
//   IR_branch     out 13  IR[12:0]
//   IR_msb        out  1  IR[15]
//   PC            out 16  program counter (byte address)
//   busy          out  1  state is not IDLE
//   fetch_done    out  1  one-cycle pulse after a completed fetch
//   fetch_err     out  1  one-cycle pulse after a timeout abort
// ---------------------------------------------------------------------------
module ir_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start_fetch,
  input  logic        pc_load,
  input  logic [15:0] SEOUT,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] IR,
  output logic [10:0] IR_immediate,
  output logic [12:0] IR_branch,
  output logic        IR_msb,
  output logic [15:0] PC,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  // Counts completed REQ cycles; the last permitted cycle is TIMEOUT_CYCLES-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // pc_load has priority; a coincident start_fetch is dropped.
        if (pc_load) begin
          pc_d = pc_q + SEOUT;
        end else if (start_fetch) begin
          state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd2;
          state_d = S_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs decoded from registered state only
  assign mem_req      = (state_q == S_REQ);
  assign busy         = (state_q != S_IDLE);
  assign fetch_done   = (state_q == S_DONE);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err    = (state_q == S_ERR);
`else
  assign fetch_err    = 1'b0;
`endif
  assign mem_addr     = pc_q;
  assign PC           = pc_q;
  assign IR           = ir_q;
  assign IR_immediate = ir_q[10:0];
  assign IR_branch    = ir_q[12:0];
  assign IR_msb       = ir_q[15];

endmodule
